// File: rtl/acq_event_dispatcher_if.sv
// acq_event_dispatcher_if: event FIFO pop port plus command-manager readout handshake.
// The master modport is the dispatcher side; the slave modport is the FIFO/command-manager side.
interface acq_event_dispatcher_if;
  logic        fifo_valid;
  logic [31:0] fifo_data;
  logic        fifo_ready;
  logic        cm_readout_req;
  logic [2:0]  cm_trig_type;
  logic [23:0] cm_trig_num;
  logic        cm_readout_ack;
  logic        cm_readout_complete;
  modport master (
    input  fifo_valid, fifo_data, cm_readout_ack, cm_readout_complete,
    output fifo_ready, cm_readout_req, cm_trig_type, cm_trig_num
  );
  modport slave (
    output fifo_valid, fifo_data, cm_readout_ack, cm_readout_complete,
    input  fifo_ready, cm_readout_req, cm_trig_type, cm_trig_num
  );
endinterface

// File: rtl/acq_event_dispatcher.sv
// acq_event_dispatcher: pops acquisition events, checks sequence/format, runs one readout per event.
// Optional trigger-type filtering is compiled in with TYPE_FILTER_EN.
module acq_event_dispatcher #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
  parameter logic [7:0]  TYPE_MASK      = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  acq_event_dispatcher_if.master       bus,
  output logic                         readout_done,
  input  logic                         err_clear,
  output logic                         seq_error,
  output logic                         format_error,
  output logic                         timeout_error,
  output logic [23:0]                  err_trig_num,
  output logic [31:0]                  event_count,
  output logic [4:0]                   state
);
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    REQUEST = 5'b00010,
    BUSY    = 5'b00100,
    DONE    = 5'b01000,
    DROP    = 5'b10000
  } state_t;
  state_t      st;
  logic        first_event;
  logic [23:0] last_num;
  logic [23:0] cnt;
  logic        disp;
  logic        pop;
  logic [23:0] num;
  assign state = st;
  assign num   = bus.fifo_data[23:0];
  assign pop   = bus.fifo_valid & bus.fifo_ready;
`ifdef TYPE_FILTER_EN
  assign disp = TYPE_MASK[bus.fifo_data[26:24]];
`else
  // mask has no effect without filtering; every event is dispatched
  assign disp = |{1'b1, TYPE_MASK};
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st                 <= IDLE;
      bus.fifo_ready     <= 1'b0;
      bus.cm_readout_req <= 1'b0;
      bus.cm_trig_type   <= 3'd0;
      bus.cm_trig_num    <= 24'd0;
      readout_done       <= 1'b0;
      seq_error          <= 1'b0;
      format_error       <= 1'b0;
      timeout_error      <= 1'b0;
      err_trig_num       <= 24'd0;
      event_count        <= 32'd0;
      first_event        <= 1'b1;
      last_num           <= 24'd0;
      cnt                <= 24'd0;
    end else begin
      readout_done  <= 1'b0;
      seq_error     <= seq_error & ~err_clear;
      format_error  <= format_error & ~err_clear;
      timeout_error <= timeout_error & ~err_clear;
      case (st)
        IDLE: begin
          bus.fifo_ready <= ~pop;
          if (pop) begin
            bus.cm_trig_type <= bus.fifo_data[26:24];
            bus.cm_trig_num  <= num;
            if (|bus.fifo_data[31:27]) format_error <= 1'b1;
            if (!first_event && num != last_num + 24'd1) begin
              seq_error    <= 1'b1;
              err_trig_num <= num;
            end
            last_num           <= num;
            first_event        <= 1'b0;
            st                 <= disp ? REQUEST : DROP;
            bus.cm_readout_req <= disp;
            readout_done       <= ~disp;
          end
        end
        REQUEST:
          if (bus.cm_readout_ack) begin
            bus.cm_readout_req <= 1'b0;
            st                 <= bus.cm_readout_complete ? DONE : BUSY;
            readout_done       <= bus.cm_readout_complete;
          end
        BUSY:
          if (bus.cm_readout_complete || cnt == TIMEOUT_CYCLES - 24'd1) begin
            if (!bus.cm_readout_complete) timeout_error <= 1'b1;
            cnt          <= 24'd0;
            st           <= DONE;
            readout_done <= 1'b1;
          end else cnt <= cnt + 24'd1;
        DONE: begin
          event_count    <= event_count + 32'd1;
          st             <= IDLE;
          bus.fifo_ready <= 1'b1;
        end
        DROP: begin
          st             <= IDLE;
          bus.fifo_ready <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_acq_event_dispatcher.sv
// tb_acq_event_dispatcher: randomized and directed checks against an event-level reference model.
`timescale 1ns/1ps
module tb_acq_event_dispatcher;
  localparam logic [23:0] T      = 24'd16;
  localparam logic [7:0]  MASK   = 8'hFD;
  localparam logic [4:0]  S_IDLE = 5'b00001;
  localparam logic [4:0]  S_BUSY = 5'b00100;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        err_clear = 1'b0;
  logic        readout_done, seq_error, format_error, timeout_error;
  logic [23:0] err_trig_num;
  logic [31:0] event_count;
  logic [4:0]  state;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_first, m_seq, m_fmt, m_tmo;
  logic [23:0] m_last, m_err;
  logic [31:0] m_count;

  acq_event_dispatcher_if bus();

  acq_event_dispatcher #(.TIMEOUT_CYCLES(T), .TYPE_MASK(MASK)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .readout_done(readout_done),
    .err_clear(err_clear), .seq_error(seq_error), .format_error(format_error),
    .timeout_error(timeout_error), .err_trig_num(err_trig_num),
    .event_count(event_count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit dispatched(input logic [2:0] t);
`ifdef TYPE_FILTER_EN
    return MASK[t];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_first = 1; m_last = 0; m_err = 0; m_seq = 0; m_fmt = 0; m_tmo = 0; m_count = 0;
  endtask

  // clear lands before the sets of the same event, so a simultaneous set survives
  task automatic model_event(input logic [31:0] w, input bit clr, input bit tmo);
    if (clr) begin m_seq = 0; m_fmt = 0; m_tmo = 0; end
    if (w[31:27] != 5'd0) m_fmt = 1;
    if (!m_first && w[23:0] != m_last + 24'd1) begin m_seq = 1; m_err = w[23:0]; end
    m_last = w[23:0];
    m_first = 0;
    if (dispatched(w[26:24])) begin
      if (tmo) m_tmo = 1;
      m_count = m_count + 32'd1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.fifo_valid = 0; bus.fifo_data = 0; bus.cm_readout_ack = 0; bus.cm_readout_complete = 0; err_clear = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_seq = 0; m_fmt = 0; m_tmo = 0;
  endtask

  // one full event: pop, then ack at cycle a, complete at cycle a+d (never if nc)
  task automatic run_event(input logic [31:0] w, input int a, input int d, input bit nc, input bit clr,
                           output int done_cnt, output int done_at, output bit req_seen,
                           output logic [2:0] rt, output logic [23:0] rn, output bit rdy0,
                           output bit hung, output bit unstable);
    int  k;
    bit  idle;
    k = 0; idle = 0; hung = 0; done_cnt = 0; done_at = -1; req_seen = 0; unstable = 0;
    while (!bus.fifo_ready && k < 8) begin @(negedge clk); k++; end
    if (!bus.fifo_ready) hung = 1;
    bus.fifo_valid = 1; bus.fifo_data = w; err_clear = clr;
    @(negedge clk);
    bus.fifo_valid = 0; bus.fifo_data = $urandom; err_clear = 0;
    rdy0 = bus.fifo_ready; rt = bus.cm_trig_type; rn = bus.cm_trig_num;
    model_event(w, clr, nc);
    for (int c = 0; c < 64; c++) begin
      if (readout_done) begin done_cnt++; done_at = c; end
      if (bus.cm_readout_req) begin
        req_seen = 1;
        if (bus.cm_trig_type !== rt || bus.cm_trig_num !== rn) unstable = 1;
      end
      if (c > 0 && state == S_IDLE) begin idle = 1; break; end
      bus.cm_readout_ack = (c == a);
      bus.cm_readout_complete = !nc && (c == a + d);
      @(negedge clk);
    end
    bus.cm_readout_ack = 0; bus.cm_readout_complete = 0;
    if (!idle) hung = 1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %b want %b", state, S_IDLE); end
    n_cmp++;
    if ({bus.fifo_ready, bus.cm_readout_req, bus.cm_trig_type, bus.cm_trig_num, readout_done, seq_error,
         format_error, timeout_error, err_trig_num, event_count} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: some output nonzero, want all zero");
    end
    do_reset();
    n_cmp++; if (bus.fifo_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.fifo_ready); end
  endtask

  task automatic test_basic();
    int dc, da; bit rs, r0, h, u; logic [2:0] rt; logic [23:0] rn; bit ds;
    do_reset();
    ds = dispatched(3'd1);
    run_event(32'h0100_0005, 2, 10, 0, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if (r0 !== 1'b0) begin n_bad++; $display("FAIL basic_ready_low: got %b want 0", r0); end
    n_cmp++; if (rs !== ds) begin n_bad++; $display("FAIL basic_req: got %b want %b", rs, ds); end
    n_cmp++; if ({rt, rn} !== {3'd1, 24'd5}) begin n_bad++; $display("FAIL basic_latch: got %0d/%0d want 1/5", rt, rn); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL basic_done_pulses: got %0d want 1", dc); end
    n_cmp++; if (da !== (ds ? 13 : 0)) begin n_bad++; $display("FAIL basic_done_latency: got %0d want %0d", da, ds ? 13 : 0); end
    n_cmp++; if (event_count !== (ds ? 32'd1 : 32'd0)) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", event_count, ds); end
    n_cmp++; if (h !== 1'b0 || u !== 1'b0) begin n_bad++; $display("FAIL basic_hang_or_unstable: got %b%b want 00", h, u); end
  endtask

  task automatic test_sequence();
    int dc, da; bit rs, r0, h, u; logic [2:0] rt; logic [23:0] rn;
    do_reset();
    run_event(32'h0000_0005, 0, 1, 0, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL seq_first: got %b want 0", seq_error); end
    run_event(32'h0000_0007, 0, 1, 0, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if ({seq_error, err_trig_num} !== {1'b1, 24'd7}) begin n_bad++; $display("FAIL seq_gap: got %b/%0h want 1/7", seq_error, err_trig_num); end
    clear_errors();
    n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL seq_clear: got %b want 0", seq_error); end
    n_cmp++; if (err_trig_num !== 24'd7) begin n_bad++; $display("FAIL seq_num_kept: got %0h want 7", err_trig_num); end
    run_event(32'h00FF_FFFF, 1, 2, 0, 1, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if ({seq_error, err_trig_num} !== {1'b1, 24'hFFFFFF}) begin n_bad++; $display("FAIL seq_set_wins: got %b/%0h want 1/ffffff", seq_error, err_trig_num); end
    clear_errors();
    run_event(32'h0000_0000, 1, 2, 0, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL seq_wrap: got %b want 0", seq_error); end
  endtask

  task automatic test_format();
    int dc, da; bit rs, r0, h, u; logic [2:0] rt; logic [23:0] rn;
    do_reset();
    run_event(32'h0800_0001, 1, 3, 0, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if (format_error !== 1'b1) begin n_bad++; $display("FAIL fmt_flag: got %b want 1", format_error); end
    n_cmp++; if ({rs, dc, da} !== {1'b1, 32'd1, 32'd5}) begin n_bad++; $display("FAIL fmt_readout: got req %b done %0d at %0d want 1/1/5", rs, dc, da); end
    n_cmp++; if (event_count !== 32'd1) begin n_bad++; $display("FAIL fmt_count: got %0d want 1", event_count); end
  endtask

  task automatic test_timeout();
    int dc, da; bit rs, r0, h, u; logic [2:0] rt; logic [23:0] rn;
    do_reset();
    run_event(32'h0000_0010, 1, 0, 1, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if (timeout_error !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", timeout_error); end
    n_cmp++; if (da !== 1 + int'(T) + 1) begin n_bad++; $display("FAIL tmo_latency: got %0d want %0d", da, 1 + int'(T) + 1); end
    n_cmp++; if ({dc, h, state} !== {32'd1, 1'b0, S_IDLE}) begin n_bad++; $display("FAIL tmo_done_idle: got %0d/%b/%b want 1/0/idle", dc, h, state); end
  endtask

  task automatic test_back_to_back();
    int dc, da; bit rs, r0, h, u; logic [2:0] rt; logic [23:0] rn;
    do_reset();
    run_event(32'h0000_0020, 1, 0, 0, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if ({dc, da} !== {32'd1, 32'd2}) begin n_bad++; $display("FAIL same_cycle_ack: got %0d at %0d want 1 at 2", dc, da); end
    run_event(32'h0000_0021, 0, 0, 0, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if ({dc, da, timeout_error} !== {32'd1, 32'd1, 1'b0}) begin n_bad++; $display("FAIL immediate_ack: got %0d at %0d tmo %b want 1 at 1 tmo 0", dc, da, timeout_error); end
    bus.cm_readout_complete = 1;
    dc = 0;
    repeat (3) begin @(negedge clk); dc += int'(readout_done); end
    bus.cm_readout_complete = 0;
    n_cmp++; if ({dc, state} !== {32'd0, S_IDLE}) begin n_bad++; $display("FAIL stray_complete: got %0d pulses state %b want 0/idle", dc, state); end
    n_cmp++; if (event_count !== 32'd2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", event_count); end
  endtask

  task automatic test_reset_mid_busy();
    int dc, da, seen; bit rs, r0, h, u; logic [2:0] rt; logic [23:0] rn;
    do_reset();
    bus.fifo_valid = 1; bus.fifo_data = 32'h0000_0040;
    @(negedge clk);
    bus.fifo_valid = 0; bus.cm_readout_ack = 1;
    @(negedge clk);
    bus.cm_readout_ack = 0;
    n_cmp++; if (state !== S_BUSY) begin n_bad++; $display("FAIL midrst_busy: got %b want %b", state, S_BUSY); end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.fifo_ready, bus.cm_readout_req, bus.cm_trig_num, readout_done, event_count, state} !== {1'b0, 1'b0, 24'd0, 1'b0, 32'd0, S_IDLE}) begin
      n_bad++; $display("FAIL midrst_async: req %b done %b count %0d state %b want 0/0/0/idle", bus.cm_readout_req, readout_done, event_count, state);
    end
    seen = 0;
    bus.cm_readout_complete = 1;
    repeat (3) begin @(posedge clk); #1 seen += int'(readout_done); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (4) begin @(negedge clk); seen += int'(readout_done); end
    bus.cm_readout_complete = 0;
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen); end
    run_event(32'h0000_0099, 0, 1, 0, 0, dc, da, rs, rt, rn, r0, h, u);
    n_cmp++; if ({seq_error, event_count} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL midrst_restart: got seq %b count %0d want 0/1", seq_error, event_count); end
  endtask

  task automatic test_random();
    int dc, da, a, d, exp_at; bit rs, r0, h, u, nc, clr, ds; logic [2:0] rt; logic [23:0] rn;
    logic [31:0] w; logic [23:0] nx;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      nx = ($urandom % 4 == 0) ? 24'($urandom) : m_last + 24'd1;
      w = {($urandom % 8 == 0) ? 5'($urandom_range(1, 31)) : 5'd0, 3'($urandom), nx};
      a = $urandom_range(0, 3); d = $urandom_range(0, 12);
      nc = ($urandom % 8 == 0); clr = ($urandom % 6 == 0);
      ds = dispatched(w[26:24]);
      exp_at = !ds ? 0 : nc ? a + int'(T) + 1 : a + d + 1;
      run_event(w, a, d, nc, clr, dc, da, rs, rt, rn, r0, h, u);
      n_cmp++; if ({dc, da} !== {32'd1, exp_at}) begin n_bad++; $display("FAIL rnd%0d_done: got %0d at %0d want 1 at %0d", i, dc, da, exp_at); end
      n_cmp++; if ({rs, rt, rn} !== {ds, w[26:24], w[23:0]}) begin n_bad++; $display("FAIL rnd%0d_req: got %b %0d %0h want %b %0d %0h", i, rs, rt, rn, ds, w[26:24], w[23:0]); end
      n_cmp++; if ({r0, h, u} !== 3'b000) begin n_bad++; $display("FAIL rnd%0d_flow: ready/hang/unstable got %b%b%b want 000", i, r0, h, u); end
      n_cmp++; if ({seq_error, format_error, timeout_error} !== {m_seq, m_fmt, m_tmo}) begin n_bad++; $display("FAIL rnd%0d_flags: got %b%b%b want %b%b%b", i, seq_error, format_error, timeout_error, m_seq, m_fmt, m_tmo); end
      n_cmp++; if ({err_trig_num, event_count} !== {m_err, m_count}) begin n_bad++; $display("FAIL rnd%0d_regs: got %0h/%0d want %0h/%0d", i, err_trig_num, event_count, m_err, m_count); end
    end
  endtask

  initial begin
    bus.fifo_valid = 0; bus.fifo_data = 0; bus.cm_readout_ack = 0; bus.cm_readout_complete = 0;
    model_reset();
    test_reset();
    test_basic();
    test_sequence();
    test_format();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
